stopwatch_bcd: RTL and testbench
================================

// Module: stopwatch_bcd
// PURPOSE
//  Downstream consumer of the clock-divider stage. Takes the divided square
//  wave (f_out of the divider) as tick_in, counts one unit per tick_in rising
//  edge into a 4-digit BCD MM:SS value, and applies start/stop/clear control.
//  The BCD digits feed the display stage. Everything runs on clk.
// PARAMETERS
//  SCAN_DIV  16'd1000  clk cycles per display digit slot (used only with SEG7_SCAN_EN)
// PORTS
//  clk      in   1   system clock; also clocks the divider that drives tick_in
//  rst      in   1   asynchronous, active-low reset
//  tick_in  in   1   divided square wave from divider f_out, registered on clk
//  start    in   1   level/pulse: enter RUN
//  stop     in   1   level/pulse: RUN -> PAUSE
//  clr      in   1   zero the count and return to IDLE
//  digits   out  16  BCD {min_hi,min_lo,sec_hi,sec_lo}
//  running  out  1   1 while state==RUN
//  wrap     out  1   one-clk pulse on 59:59 -> 00:00
// BEHAVIOUR
//  Reset (rst==0, async): digits=16'h0000, running=0, wrap=0, state=IDLE,
//   tick_d=1. tick_d resets to 1 so a high tick_in out of reset is not
//   counted as an edge.
//  Edge detect: tick_d <= tick_in every clk; tick_pls = tick_in & ~tick_d
//   (combinational). One count per divider period, independent of duty.
//  FSM states: IDLE, RUN, PAUSE. Control priority: clr > stop > start.
//   any state, clr=1       -> IDLE, digits<=0
//   IDLE/PAUSE, start=1    -> RUN
//   RUN, stop=1            -> PAUSE
//   otherwise              -> hold
//   running is registered: it equals (next_state==RUN).
//  Counting: a tick is counted when the current state is RUN, tick_pls=1 and
//   clr=0.
//   - A tick in the cycle that stop is asserted in RUN IS counted.
//   - A tick in the cycle that start is asserted from IDLE/PAUSE is NOT counted.
//   - clr together with a tick: clr wins, digits=0 and nothing is counted.
//  Latency: tick_in rises after edge N -> digits update at edge N+1.
//  Digit chain on a counted tick:
//   - sec_lo 0..9, carry to sec_hi 0..5, then min_lo 0..9, then min_hi 0..5.
//   - Each digit goes back to 0 when its carry-out fires.
//   - 59:59 + tick -> 00:00, and wrap=1 for exactly that one clk.
//   - wrap=0 otherwise.
//  Digits never hold non-BCD values. Counting stops in PAUSE (digits hold)
//   and in IDLE (digits=0).
//  Reset mid-count forces the reset values immediately. No tick is counted
//   on the first edge after reset is released.
// CONFIGURATION
//  SEG7_SCAN_EN defined:
//   - Adds ports seg[6:0] (active-low a..g) and an[3:0] (active-low digit
//     enable).
//   - A scan counter steps the active digit every SCAN_DIV clks, in the
//     order an=1110 (sec_lo), 1101, 1011, 0111, then wraps.
//   - seg is the combinational decode of the selected digit.
//   - Reset values: an=4'b1110, seg=decode(0)=7'b1000000, scan counter=0.
//  SEG7_SCAN_EN undefined: the seg/an ports and the scan logic are absent.
//   Only the BCD digits are output.
// TESTING
//  1 rst=0 with tick_in=1, then release rst -> digits=0000, running=0, no
//    count on the first edge after release.
//  2 start pulse, then 10 tick_in periods -> digits=16'h0010, running=1.
//  3 Preload to 59:58 by ticking, then 2 ticks -> 59:59, then 00:00. wrap
//    is high for exactly 1 clk, coincident with 00:00.
//  4 In RUN, assert stop in the same clk as a tick edge -> that tick is
//    counted, then digits hold over 5 further ticks. start -> counting resumes.
//  5 clr and a tick edge in the same clk while RUN -> digits=0000, state IDLE,
//    running=0. Then 3 ticks -> still 0000.
//  6 SEG7_SCAN_EN, SCAN_DIV=4, digits=12:34 -> an/seg sequence 1110/4,
//    1101/3, 1011/2, 0111/1, with each slot lasting 4 clks.

Source files
------------

// File: rtl/stopwatch_bcd_if.sv
// Control and result bundle for the stopwatch_bcd MM:SS counter.
// With SEG7_SCAN_EN defined, the bundle also carries the seg/an display-scan outputs.
interface stopwatch_bcd_if;
  logic        tick_in;
  logic        start;
  logic        stop;
  logic        clr;
  logic [15:0] digits;
  logic        running;
  logic        wrap;
`ifdef SEG7_SCAN_EN
  logic [6:0]  seg;
  logic [3:0]  an;
`endif

  modport master (
    output tick_in, start, stop, clr,
    input  digits, running, wrap
`ifdef SEG7_SCAN_EN
    , input seg, an
`endif
  );

  modport slave (
    input  tick_in, start, stop, clr,
    output digits, running, wrap
`ifdef SEG7_SCAN_EN
    , output seg, an
`endif
  );
endinterface

// File: rtl/stopwatch_bcd.sv
// BCD MM:SS stopwatch that counts rising edges of the divided tick and has start/stop/clr control.
// Defining SEG7_SCAN_EN adds a multiplexed active-low 7-segment scan driven on seg/an.
module stopwatch_bcd #(
  parameter logic [15:0] SCAN_DIV = 16'd1000
) (
  input  logic           clk,
  input  logic           rst,
  stopwatch_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t      state_q, state_d;
  logic        tick_q, tick_d;
  logic [15:0] digits_q, digits_d;
  logic        running_q, running_d;
  logic        wrap_q, wrap_d;
  logic        tick_pls;
  logic        count_en;
  logic        c0, c1, c2, c3;
  logic [3:0]  s_lo, s_hi, m_lo, m_hi;

  assign s_lo = digits_q[3:0];
  assign s_hi = digits_q[7:4];
  assign m_lo = digits_q[11:8];
  assign m_hi = digits_q[15:12];

  // Carry chain: each carry needs every lower digit to be at its maximum value.
  assign c0 = (s_lo == 4'd9);
  assign c1 = c0 & (s_hi == 4'd5);
  assign c2 = c1 & (m_lo == 4'd9);
  assign c3 = c2 & (m_hi == 4'd5);

  always_comb begin
    tick_d    = bus.tick_in;
    tick_pls  = bus.tick_in & ~tick_q;
    state_d   = state_q;
    digits_d  = digits_q;
    wrap_d    = 1'b0;
    count_en  = (state_q == RUN) & tick_pls & ~bus.clr;

    if (bus.clr) begin
      state_d = IDLE;
    end else if ((state_q == RUN) && bus.stop) begin
      state_d = PAUSE;
    end else if ((state_q != RUN) && bus.start) begin
      state_d = RUN;
    end

    if (bus.clr) begin
      digits_d = 16'h0000;
    end else if (count_en) begin
      digits_d[3:0]   = c0 ? 4'd0 : s_lo + 4'd1;
      digits_d[7:4]   = c0 ? (c1 ? 4'd0 : s_hi + 4'd1) : s_hi;
      digits_d[11:8]  = c1 ? (c2 ? 4'd0 : m_lo + 4'd1) : m_lo;
      digits_d[15:12] = c2 ? (c3 ? 4'd0 : m_hi + 4'd1) : m_hi;
      wrap_d          = c3;
    end

    running_d = (state_d == RUN);
  end

  // tick_q resets high so that a tick_in already high at release is not seen as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= 1'b1;
      digits_q  <= 16'h0000;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      digits_q  <= digits_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

`ifdef SEG7_SCAN_EN
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic        slot_end;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    slot_end   = (scan_cnt_q == SCAN_DIV - 16'd1);
    scan_cnt_d = slot_end ? 16'd0 : scan_cnt_q + 16'd1;
    sel_d      = slot_end ? sel_q + 2'd1 : sel_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= 16'd0;
      sel_q      <= 2'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.an  = ~(4'b0001 << sel_q);
  assign bus.seg = seg_decode(digits_q[{sel_q, 2'b00} +: 4]);
`else
  // SCAN_DIV only matters for the display scan; this empty check keeps the parameter referenced.
  if (SCAN_DIV == 16'd0) begin : g_scan_div_zero
  end
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Randomized and directed checks of stopwatch_bcd against a seconds-counter reference model.
// The display-scan test runs only when SEG7_SCAN_EN is defined.
module tb_stopwatch_bcd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  stopwatch_bcd_if bus();

  stopwatch_bcd #(.SCAN_DIV(16'd4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed seconds as a plain integer plus a run flag.
  int m_secs = 0;
  bit m_run  = 1'b0;
  bit m_wrap = 1'b0;
  bit m_prev = 1'b1;

  always @(posedge clk or negedge rst) begin
    bit pls;
    if (!rst) begin
      m_secs = 0; m_run = 1'b0; m_wrap = 1'b0; m_prev = 1'b1;
    end else begin
      pls    = bus.tick_in && !m_prev;
      m_prev = bus.tick_in;
      m_wrap = 1'b0;
      if (bus.clr) begin
        m_secs = 0; m_run = 1'b0;
      end else begin
        if (m_run && pls) begin
          m_secs++;
          if (m_secs == 3600) begin m_secs = 0; m_wrap = 1'b1; end
        end
        if (m_run && bus.stop) m_run = 1'b0;
        else if (!m_run && bus.start) m_run = 1'b1;
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    to_bcd = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_in = 1'b1; cyc();
      bus.tick_in = 1'b0; cyc();
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1; cyc(); bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.tick_in = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0;
    cyc(); cyc();
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: digits=%h running=%b wrap=%b, want 0000/0/0", bus.digits, bus.running, bus.wrap);
    end
    rst = 1'b1;
    cyc(); cyc();
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: digits=%h running=%b, want 0000/0", bus.digits, bus.running);
    end
    // A high tick_in at release must not count even once RUN is entered.
    pulse_start(); cyc();
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_edge: digits=%h running=%b, want 0000/1", bus.digits, bus.running);
    end
    bus.tick_in = 1'b0; pulse_clr(); cyc();
  endtask

  task automatic test_count();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bus.tick_in = 1'b1; cyc(); cyc();
      bus.tick_in = 1'b0; cyc(); cyc(); cyc();
    end
    vectors++;
    if (bus.digits !== 16'h0010 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL count_10: digits=%h running=%b, want 0010/1", bus.digits, bus.running);
    end
    vectors++;
    if (bus.digits !== to_bcd(m_secs)) begin
      errors++;
      $display("FAIL count_model: digits=%h model=%h", bus.digits, to_bcd(m_secs));
    end
  endtask

  task automatic test_wrap();
    int wrap_seen;
    pulse_clr(); pulse_start();
    wrap_seen = 0;
    for (int i = 0; i < 3599; i++) begin
      bus.tick_in = 1'b1; cyc(); if (bus.wrap) wrap_seen++;
      bus.tick_in = 1'b0; cyc(); if (bus.wrap) wrap_seen++;
    end
    vectors++;
    if (bus.digits !== 16'h5959 || wrap_seen != 0) begin
      errors++;
      $display("FAIL wrap_preload: digits=%h early_wraps=%0d, want 5959/0", bus.digits, wrap_seen);
    end
    bus.tick_in = 1'b1; cyc();
    vectors++;
    if (bus.digits !== 16'h0000 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL wrap_edge: digits=%h wrap=%b, want 0000/1", bus.digits, bus.wrap);
    end
    bus.tick_in = 1'b0; cyc();
    vectors++;
    if (bus.wrap !== 1'b0 || bus.digits !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_pulse_len: wrap=%b digits=%h, want 0/0000", bus.wrap, bus.digits);
    end
  endtask

  task automatic test_stop_tick();
    pulse_clr(); pulse_start(); ticks(3);
    bus.tick_in = 1'b1; bus.stop = 1'b1; cyc();
    bus.stop = 1'b0; bus.tick_in = 1'b0; cyc();
    vectors++;
    if (bus.digits !== 16'h0004 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL stop_with_tick: digits=%h running=%b, want 0004/0", bus.digits, bus.running);
    end
    ticks(5);
    vectors++;
    if (bus.digits !== 16'h0004) begin
      errors++;
      $display("FAIL pause_hold: digits=%h, want 0004", bus.digits);
    end
    bus.tick_in = 1'b1; bus.start = 1'b1; cyc();
    bus.start = 1'b0; bus.tick_in = 1'b0; cyc();
    vectors++;
    if (bus.digits !== 16'h0004 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL start_with_tick: digits=%h running=%b, want 0004/1", bus.digits, bus.running);
    end
    ticks(2);
    vectors++;
    if (bus.digits !== 16'h0006) begin
      errors++;
      $display("FAIL resume: digits=%h, want 0006", bus.digits);
    end
  endtask

  task automatic test_clr_tick();
    ticks(5);
    bus.tick_in = 1'b1; bus.clr = 1'b1; cyc();
    bus.clr = 1'b0; bus.tick_in = 1'b0;
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL clr_with_tick: digits=%h running=%b, want 0000/0", bus.digits, bus.running);
    end
    cyc(); ticks(3);
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: digits=%h running=%b, want 0000/0", bus.digits, bus.running);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      bus.tick_in = ($urandom_range(0, 2) == 0) ? ~bus.tick_in : bus.tick_in;
      bus.start   = ($urandom_range(0, 19) == 0);
      bus.stop    = ($urandom_range(0, 29) == 0);
      bus.clr     = ($urandom_range(0, 199) == 0);
      cyc();
      vectors++;
      if (bus.digits !== to_bcd(m_secs) || bus.running !== m_run || bus.wrap !== m_wrap) begin
        errors++;
        if (bad < 5)
          $display("FAIL random_cyc%0d: digits=%h run=%b wrap=%b, model %h/%b/%b",
                   i, bus.digits, bus.running, bus.wrap, to_bcd(m_secs), m_run, m_wrap);
        bad++;
      end
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic test_midreset();
    pulse_clr(); pulse_start(); ticks(7);
    #3 rst = 1'b0;
    #1;
    vectors++;
    if (bus.digits !== 16'h0000 || bus.running !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL midreset: digits=%h running=%b wrap=%b, want 0000/0/0", bus.digits, bus.running, bus.wrap);
    end
    cyc(); rst = 1'b1; cyc();
  endtask

`ifdef SEG7_SCAN_EN
  task automatic test_scan();
    logic [6:0] seg_tab [10];
    logic [3:0] want_an;
    logic [6:0] want_seg;
    int waited;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    vectors++;
    if (bus.an !== 4'b1110 && bus.an !== 4'b1101 && bus.an !== 4'b1011 && bus.an !== 4'b0111) begin
      errors++;
      $display("FAIL scan_onehot: an=%b", bus.an);
    end
    pulse_clr(); pulse_start(); ticks(754);
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
    // Align to the cycle where the scan has just entered slot sec_lo.
    waited = 0;
    while (!(bus.an === 4'b1110 && waited > 0 && dut.scan_cnt_q == 16'd0) && waited < 40) begin
      cyc(); waited++;
    end
    vectors++;
    if (waited >= 40) begin
      errors++;
      $display("FAIL scan_align: an=%b never entered slot 0", bus.an);
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        want_an  = ~(4'b0001 << k);
        want_seg = seg_tab[4 - k];
        vectors++;
        if (bus.an !== want_an || bus.seg !== want_seg) begin
          errors++;
          $display("FAIL scan_slot%0d_clk%0d: an=%b seg=%b, want %b/%b", k, c, bus.an, bus.seg, want_an, want_seg);
        end
        cyc();
      end
    end
  endtask
`endif

  initial begin
    bus.tick_in = 1'b1; bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0;
    test_reset();
    test_count();
    test_wrap();
    test_stop_tick();
    test_clr_tick();
    test_random();
    test_midreset();
`ifdef SEG7_SCAN_EN
    test_scan();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
